// File: rtl/ula_pkg.sv
// Shared codes and types for the bit-serial ALU: function/shift encodings,
// FSM state constants and the captured control word.
package ula_pkg;

   localparam logic [1:0] FN_AND  = 2'b00;
   localparam logic [1:0] FN_OR   = 2'b01;
   localparam logic [1:0] FN_NOTB = 2'b10;
   localparam logic [1:0] FN_ADD  = 2'b11;

   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_SRA1 = 2'b01;
   localparam logic [1:0] SH_SLL8 = 2'b10;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'b00;
   localparam state_t ST_RUN   = 2'b01;
   localparam state_t ST_SHIFT = 2'b10;

   // Control word latched at start; inc is consumed directly into the carry
   typedef struct packed {
      logic       f0;
      logic       f1;
      logic       ena;
      logic       enb;
      logic       inva;
      logic [1:0] sh;
   } ctrl_t;

endpackage

// File: rtl/ula_slice.sv
// One-bit ALU slice: operand gating/inversion followed by AND, OR, NOT b or
// full add. Carry-out is forced low for the logic functions.
module ula_slice
   import ula_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic f0,
   input  logic f1,
   input  logic ena,
   input  logic enb,
   input  logic inva,
   output logic y,
   output logic co
);

   logic a_eff;
   logic b_eff;

   always_comb begin
      a_eff = (a & ena) ^ inva;
      b_eff = b & enb;
      y     = 1'b0;
      co    = 1'b0;
      case ({f0, f1})
         FN_AND:  y = a_eff & b_eff;
         FN_OR:   y = a_eff | b_eff;
         FN_NOTB: y = ~b_eff;
         FN_ADD: begin
            y  = a_eff ^ b_eff ^ cin;
            co = (a_eff & b_eff) | (cin & (a_eff ^ b_eff));
         end
         default: y = 1'b0;
      endcase
   end

endmodule

// File: rtl/ula_serial.sv
// Bit-serial ALU: captures operands on start, processes one bit per clock
// LSB first through a single slice, then applies the post-shift and flags.
module ula_serial
   import ula_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             f0,
   input  logic             f1,
   input  logic             ena,
   input  logic             enb,
   input  logic             inva,
   input  logic             inc,
   input  logic [1:0]       sh,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             n_flag,
   output logic             z_flag,
   output logic             cout
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t             state;
   state_t             state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   acc;
   ctrl_t              ctrl_q;
   logic               carry;
   logic               slice_y;
   logic               slice_co;
   logic               last_bit_c;
   logic               fn_add_c;
   logic [WIDTH-1:0]   shifted_c;

   assign last_bit_c = (cnt == CNT_W'(WIDTH - 1));
   assign fn_add_c   = ({ctrl_q.f0, ctrl_q.f1} == FN_ADD);

   ula_slice u_slice (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry),
      .f0   (ctrl_q.f0),
      .f1   (ctrl_q.f1),
      .ena  (ctrl_q.ena),
      .enb  (ctrl_q.enb),
      .inva (ctrl_q.inva),
      .y    (slice_y),
      .co   (slice_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (start) state_nx = ST_RUN;
         ST_RUN:   if (last_bit_c) state_nx = ST_SHIFT;
         ST_SHIFT: state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Left shift by 8 naturally yields zero when WIDTH <= 8
   always_comb begin
      shifted_c = acc;
      case (ctrl_q.sh)
         SH_NONE: shifted_c = acc;
         SH_SRA1: shifted_c = {acc[WIDTH-1], acc[WIDTH-1:1]};
         SH_SLL8: shifted_c = acc << 8;
         default: shifted_c = acc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         acc    <= '0;
         ctrl_q <= '0;
         carry  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         n_flag <= 1'b0;
         z_flag <= 1'b0;
         cout   <= 1'b0;
      end else begin
         busy <= (state_nx != ST_IDLE);
         done <= (state == ST_SHIFT);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_q    <= a;
                  b_q    <= b;
                  ctrl_q <= '{f0: f0, f1: f1, ena: ena, enb: enb, inva: inva, sh: sh};
                  cnt    <= '0;
                  carry  <= inc;
               end
            end
            ST_RUN: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               acc   <= {slice_y, acc[WIDTH-1:1]};
               carry <= slice_co;
               cnt   <= cnt + CNT_W'(1);
            end
            ST_SHIFT: begin
               result <= shifted_c;
               n_flag <= shifted_c[WIDTH-1];
               z_flag <= (shifted_c == '0);
               cout   <= fn_add_c & carry;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ula_serial.sv
// Directed self-checking bench for ula_serial at WIDTH=8.
module tb_ula_serial;
   import ula_pkg::*;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             f0, f1, ena, enb, inva, inc;
   logic [1:0]       sh;
   logic             busy, done, n_flag, z_flag, cout;
   logic [WIDTH-1:0] result;

   int checks = 0;
   int errors = 0;

   ula_serial #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .f0(f0), .f1(f1), .ena(ena), .enb(enb), .inva(inva), .inc(inc),
      .sh(sh), .busy(busy), .done(done), .result(result),
      .n_flag(n_flag), .z_flag(z_flag), .cout(cout)
   );

   always #5 clk = ~clk;

   task automatic set_op(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] fn,
                         input logic iena, input logic ienb, input logic iinva,
                         input logic iinc, input logic [1:0] ish);
      a = ia; b = ib; {f0, f1} = fn;
      ena = iena; enb = ienb; inva = iinva; inc = iinc; sh = ish;
   endtask

   task automatic start_op(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] fn,
                           input logic iena, input logic ienb, input logic iinva,
                           input logic iinc, input logic [1:0] ish);
      @(negedge clk);
      set_op(ia, ib, fn, iena, ienb, iinva, iinc, ish);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Cycles after the start-sampling edge until done is seen (capped at 30)
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done && n < 30);
   endtask

   task automatic test_reset;
      int n;
      rst_n = 1'b0; start = 1'b0;
      set_op(8'h00, 8'h00, FN_AND, 1'b0, 1'b0, 1'b0, 1'b0, SH_NONE);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, result, n_flag, z_flag, cout} !== 13'h0) begin
         errors++;
         $display("FAIL reset_outputs got=%h want=0", {busy, done, result, n_flag, z_flag, cout});
      end
      // First start on the first edge after release: 0x7F + 0x01
      @(negedge clk);
      rst_n = 1'b1;
      set_op(8'h7F, 8'h01, FN_ADD, 1'b1, 1'b1, 1'b0, 1'b0, SH_NONE);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL first_start_busy got=%b want=1", busy);
      end
      wait_done(n);
      checks++;
      if (n !== 9) begin
         errors++;
         $display("FAIL first_latency got=%0d want=9", n);
      end
      checks++;
      if ({result, n_flag, z_flag, cout} !== {8'h80, 3'b100}) begin
         errors++;
         $display("FAIL add_7f_01 got=%h want=%h", {result, n_flag, z_flag, cout}, {8'h80, 3'b100});
      end
   endtask

   task automatic test_add_carry;
      int n;
      start_op(8'hFF, 8'h01, FN_ADD, 1'b1, 1'b1, 1'b0, 1'b0, SH_NONE);
      wait_done(n);
      checks++;
      if ({result, n_flag, z_flag, cout} !== {8'h00, 3'b011}) begin
         errors++;
         $display("FAIL add_ff_01 got=%h want=%h", {result, n_flag, z_flag, cout}, {8'h00, 3'b011});
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_one_cycle got=%b want=0", done);
      end
   endtask

   task automatic test_logic;
      int n;
      start_op(8'hF0, 8'h3C, FN_AND, 1'b1, 1'b1, 1'b0, 1'b0, SH_NONE);
      wait_done(n);
      checks++;
      if ({result, n_flag, z_flag, cout} !== {8'h30, 3'b000}) begin
         errors++;
         $display("FAIL and_f0_3c got=%h want=%h", {result, n_flag, z_flag, cout}, {8'h30, 3'b000});
      end
      start_op(8'h12, 8'h81, FN_OR, 1'b1, 1'b1, 1'b0, 1'b0, SH_NONE);
      wait_done(n);
      checks++;
      if ({result, n_flag, z_flag, cout} !== {8'h93, 3'b100}) begin
         errors++;
         $display("FAIL or_12_81 got=%h want=%h", {result, n_flag, z_flag, cout}, {8'h93, 3'b100});
      end
      // inc must not leak into a logic function
      start_op(8'hAA, 8'h0F, FN_NOTB, 1'b1, 1'b1, 1'b0, 1'b1, SH_NONE);
      wait_done(n);
      checks++;
      if ({result, n_flag, z_flag, cout} !== {8'hF0, 3'b100}) begin
         errors++;
         $display("FAIL notb_0f_inc got=%h want=%h", {result, n_flag, z_flag, cout}, {8'hF0, 3'b100});
      end
   endtask

   task automatic test_negate;
      int n;
      start_op(8'h05, 8'h77, FN_ADD, 1'b1, 1'b0, 1'b1, 1'b1, SH_NONE);
      wait_done(n);
      checks++;
      if ({result, n_flag, z_flag, cout} !== {8'hFB, 3'b100}) begin
         errors++;
         $display("FAIL negate_05 got=%h want=%h", {result, n_flag, z_flag, cout}, {8'hFB, 3'b100});
      end
      start_op(8'h55, 8'h66, FN_ADD, 1'b0, 1'b0, 1'b0, 1'b1, SH_NONE);
      wait_done(n);
      checks++;
      if ({result, n_flag, z_flag, cout} !== {8'h01, 3'b000}) begin
         errors++;
         $display("FAIL inc_only got=%h want=%h", {result, n_flag, z_flag, cout}, {8'h01, 3'b000});
      end
   endtask

   task automatic test_shift;
      int n;
      start_op(8'h80, 8'h00, FN_ADD, 1'b1, 1'b1, 1'b0, 1'b0, SH_SRA1);
      wait_done(n);
      checks++;
      if ({result, n_flag, z_flag, cout} !== {8'hC0, 3'b100}) begin
         errors++;
         $display("FAIL sra1_80 got=%h want=%h", {result, n_flag, z_flag, cout}, {8'hC0, 3'b100});
      end
      start_op(8'h80, 8'h00, FN_ADD, 1'b1, 1'b1, 1'b0, 1'b0, SH_SLL8);
      wait_done(n);
      checks++;
      if ({result, n_flag, z_flag, cout} !== {8'h00, 3'b010}) begin
         errors++;
         $display("FAIL sll8_80 got=%h want=%h", {result, n_flag, z_flag, cout}, {8'h00, 3'b010});
      end
      start_op(8'h80, 8'h00, FN_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
      wait_done(n);
      checks++;
      if ({result, n_flag, z_flag, cout} !== {8'h80, 3'b100}) begin
         errors++;
         $display("FAIL sh11_80 got=%h want=%h", {result, n_flag, z_flag, cout}, {8'h80, 3'b100});
      end
   endtask

   task automatic test_busy_ignore;
      int n;
      int d;
      start_op(8'h10, 8'h20, FN_ADD, 1'b1, 1'b1, 1'b0, 1'b0, SH_NONE);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 3) begin
            set_op(8'hAA, 8'h55, FN_OR, 1'b1, 1'b1, 1'b1, 1'b1, SH_SRA1);
            start = 1'b1;
         end
         if (n == 4) start = 1'b0;
      end while (!done && n < 30);
      checks++;
      if (n !== 9) begin
         errors++;
         $display("FAIL busy_latency got=%0d want=9", n);
      end
      checks++;
      if ({result, n_flag, z_flag, cout} !== {8'h30, 3'b000}) begin
         errors++;
         $display("FAIL busy_ignore_result got=%h want=%h", {result, n_flag, z_flag, cout}, {8'h30, 3'b000});
      end
      d = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) d++;
      end
      checks++;
      if (d !== 0) begin
         errors++;
         $display("FAIL no_queued_op got=%0d dones want=0", d);
      end
      checks++;
      if (result !== 8'h30) begin
         errors++;
         $display("FAIL result_hold got=%h want=30", result);
      end
   endtask

   task automatic test_back_to_back;
      int n;
      start_op(8'h01, 8'h02, FN_ADD, 1'b1, 1'b1, 1'b0, 1'b0, SH_NONE);
      wait_done(n);
      checks++;
      if (result !== 8'h03) begin
         errors++;
         $display("FAIL b2b_first got=%h want=03", result);
      end
      set_op(8'h04, 8'h05, FN_ADD, 1'b1, 1'b1, 1'b0, 1'b0, SH_NONE);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if ({busy, done} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_accept got=%b want=10", {busy, done});
      end
      wait_done(n);
      checks++;
      if (n !== 9) begin
         errors++;
         $display("FAIL b2b_latency got=%0d want=9", n);
      end
      checks++;
      if (result !== 8'h09) begin
         errors++;
         $display("FAIL b2b_second got=%h want=09", result);
      end
   endtask

   task automatic test_reset_mid_run;
      int n;
      int d;
      start_op(8'h11, 8'h22, FN_ADD, 1'b1, 1'b1, 1'b0, 1'b0, SH_NONE);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, result, n_flag, z_flag, cout} !== 13'h0) begin
         errors++;
         $display("FAIL mid_reset_outputs got=%h want=0", {busy, done, result, n_flag, z_flag, cout});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      d = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done) d++;
      end
      checks++;
      if ({d != 0, busy} !== 2'b00) begin
         errors++;
         $display("FAIL abort_no_done got=%0d dones busy=%b want=0 dones busy=0", d, busy);
      end
      start_op(8'h33, 8'h44, FN_ADD, 1'b1, 1'b1, 1'b0, 1'b0, SH_NONE);
      wait_done(n);
      checks++;
      if ({result, n_flag, z_flag, cout} !== {8'h77, 3'b000}) begin
         errors++;
         $display("FAIL after_reset_add got=%h want=%h", {result, n_flag, z_flag, cout}, {8'h77, 3'b000});
      end
   endtask

   initial begin
      test_reset();
      test_add_carry();
      test_logic();
      test_negate();
      test_shift();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
